serial_word_demux: RTL and testbench
====================================

# serial_word_demux

Bit-serial to parallel word demultiplexer for the Hack hardware base library: the time-domain counterpart of the bit-select mux, steering successive single-bit inputs into successive positions of a WIDTH-bit word. It accepts one bit per handshake and presents each completed word on a one-entry output buffer with valid/ready flow control. Sits between serial links (keyboard/IO shims, test loaders) and the 16-bit Hack datapath.

## Interface

- WIDTH, 16, word width in bits (>= 2).
- MSB_FIRST, 0, 0: first received bit lands in out_word[0]; 1: first bit lands in out_word[WIDTH-1].

- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous discard of the partially assembled word.
- in_bit  input  1  serial data bit.
- in_valid  input  1  in_bit is valid this cycle.
- in_ready  output  1  block accepts in_bit this cycle (transfer = in_valid && in_ready).
- out_word  output  WIDTH  completed word.
- out_valid  output  1  out_word holds an unconsumed word.
- out_ready  input  1  consumer takes out_word this cycle (transfer = out_valid && out_ready).
- bit_count  output  clog2(WIDTH)  bits held in the partial word, 0..WIDTH-1.

## Operation

- State: shift register sreg[WIDTH-1:0], counter bit_count, output register out_word, flag out_valid. Two logical states: FILLING (bit_count < WIDTH-1) and COMPLETING (bit_count == WIDTH-1).
- Reset (rst_n low, async): sreg=0, bit_count=0, out_word=0, out_valid=0. in_ready is 0 while rst_n is low.
- in_ready = !flush && !(bit_count == WIDTH-1 && out_valid && !out_ready). Only the word-completing bit can be stalled; all other bits are always accepted.
- Accepted bit, bit_count < WIDTH-1: written at position bit_count (MSB_FIRST=0) or WIDTH-1-bit_count (MSB_FIRST=1); bit_count++.
- Accepted bit, bit_count == WIDTH-1: completed word (sreg plus this bit) loaded into out_word; out_valid=1; bit_count=0; sreg cleared to 0.
- Output drain: out_valid && out_ready with no load same edge -> out_valid=0; out_word keeps last value.
- Simultaneous drain and load: new word replaces old in out_word, out_valid stays 1; no word lost or duplicated.
- flush=1: bit_count=0, sreg=0, in_bit ignored (in_ready=0). out_word/out_valid unaffected; a pending word still drains normally that cycle.
- in_valid low: no state change on input side; gaps of any length allowed mid-word.
- out_word changes only on load; stable while out_valid && !out_ready.

## Timing

- Latency: completing bit accepted at edge N -> out_valid=1 and out_word valid immediately after edge N.
- Throughput: one word per WIDTH accepted bits, no bubbles when out_ready held high.
- in_ready is combinational from bit_count, out_valid, out_ready, flush, rst_n; no other path from inputs to outputs.
- Async reset mid-word or with a pending word discards everything; first bit after rst_n rises is position 0.

## Test plan

- Reset: hold rst_n=0 two cycles -> out_word=0x0000, out_valid=0, bit_count=0, in_ready=0; release -> in_ready=1.
- WIDTH=16, MSB_FIRST=0, stream 0xA5C3 LSB first, in_valid continuous, out_ready=1 -> out_valid pulses one cycle after 16th bit with out_word=0xA5C3; back-to-back 0x1234 follows with zero stall cycles.
- Backpressure: out_ready=0, send 0x00FF then 0xFF00 -> after 31 bits in_ready=0 with bit_count=15, out_word=0x00FF; raise out_ready -> same edge accepts 16th bit, out_word=0xFF00, out_valid stays 1.
- Flush: send 5 bits of 1, assert flush one cycle -> bit_count=0, out_valid unchanged; then send 0x0001 -> out_word=0x0001 exactly.
- Async reset mid-word: 9 bits sent plus pending word 0xBEEF, pulse rst_n low between edges -> outputs zero immediately; next 16 bits of 0x5A5A yield 0x5A5A.
- MSB_FIRST=1 with random in_valid gaps: send bits 1,0,0,...,0,1 -> out_word=0x8001; compare 100 random words against reference model.

Source files
------------

// File: rtl/serial_word_demux.sv
// rtl/serial_word_demux.sv - bit-serial to parallel word demultiplexer with one-entry output buffer
module serial_word_demux #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_bit,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_word,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH)-1:0] bit_count
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] full_word;
  logic [CW-1:0]    pos;
  logic             last_bit;
  logic             take;
  logic             load;
  logic             drain;

  // Only the word-completing bit can be stalled, and only when the buffer
  // is occupied and not being drained on the same edge.
  assign last_bit = (bit_count == LAST);
  assign in_ready = rst_n && !flush && !(last_bit && out_valid && !out_ready);
  assign take     = in_valid && in_ready;
  assign load     = take && last_bit;
  assign drain    = out_valid && out_ready;
  assign pos      = MSB_FIRST ? (LAST - bit_count) : bit_count;

  // Completed word as it would look with the incoming bit merged in.
  always_comb begin
    full_word      = sreg;
    full_word[pos] = in_bit;
  end

  // Partial-word assembly: flush and word completion both restart at position 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg      <= '0;
      bit_count <= '0;
    end else if (flush) begin
      sreg      <= '0;
      bit_count <= '0;
    end else if (take) begin
      if (last_bit) begin
        sreg      <= '0;
        bit_count <= '0;
      end else begin
        sreg[pos] <= in_bit;
        bit_count <= bit_count + 1'b1;
      end
    end
  end

  // Output buffer: a load wins over a drain so a simultaneous hand-off keeps out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_word  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_word  <= full_word;
      out_valid <= 1'b1;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_word_demux.sv
// tb/tb_serial_word_demux.sv - scoreboard bench for serial_word_demux (LSB-first and MSB-first instances)
module tb_serial_word_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_bit;
  logic        in_valid;
  logic        out_ready;
  logic        in_ready,  in_ready_m;
  logic [15:0] out_word,  out_word_m;
  logic        out_valid, out_valid_m;
  logic [3:0]  bit_count, bit_count_m;

  int checks   = 0;
  int failures = 0;

  logic [15:0] sb_q[$];
  logic [15:0] m_word;
  int          m_cnt;
  logic        m_ov;
  logic        rand_rdy = 1'b0;

  always #5 clk = ~clk;

  serial_word_demux #(.WIDTH(16), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready), .out_word(out_word), .out_valid(out_valid),
    .out_ready(out_ready), .bit_count(bit_count)
  );

  serial_word_demux #(.WIDTH(16), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready_m), .out_word(out_word_m), .out_valid(out_valid_m),
    .out_ready(out_ready), .bit_count(bit_count_m)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] rev16(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = w[15-i];
    return r;
  endfunction

  // Reference model, evaluated half a cycle before each rising edge.
  always @(negedge clk) begin
    logic exp_ready;
    logic load;
    logic [15:0] exp_w;
    logic [15:0] full;
    if (!rst_n) begin
      m_word = '0;
      m_cnt  = 0;
      m_ov   = 1'b0;
      sb_q.delete();
    end else begin
      exp_ready = !flush && !(m_cnt == 15 && m_ov && !out_ready);
      check_eq("in_ready",    {31'd0, in_ready},    {31'd0, exp_ready});
      check_eq("in_ready_m",  {31'd0, in_ready_m},  {31'd0, exp_ready});
      check_eq("bit_count",   {28'd0, bit_count},   m_cnt);
      check_eq("bit_count_m", {28'd0, bit_count_m}, m_cnt);
      check_eq("out_valid",   {31'd0, out_valid},   {31'd0, m_ov});
      check_eq("out_valid_m", {31'd0, out_valid_m}, {31'd0, m_ov});
      if (m_ov && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 32'd0, 32'd1);
        end else begin
          exp_w = sb_q.pop_front();
          check_eq("out_word",   {16'd0, out_word},   {16'd0, exp_w});
          check_eq("out_word_m", {16'd0, out_word_m}, {16'd0, rev16(exp_w)});
        end
      end
      load = in_valid && exp_ready && (m_cnt == 15);
      if (in_valid && exp_ready) begin
        if (m_cnt < 15) begin
          m_word[m_cnt] = in_bit;
          m_cnt++;
        end else begin
          full     = m_word;
          full[15] = in_bit;
          sb_q.push_back(full);
          m_word = '0;
          m_cnt  = 0;
        end
      end else if (flush) begin
        m_word = '0;
        m_cnt  = 0;
      end
      if (load) m_ov = 1'b1;
      else if (m_ov && out_ready) m_ov = 1'b0;
    end
  end

  // Random consumer backpressure during the randomized phase.
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_bit(input logic b, input int gap);
    int n;
    repeat (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_bit   = b;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap_max);
    for (int i = 0; i < 16; i++) send_bit(w[i], gap_max > 0 ? int'($urandom_range(0, gap_max)) : 0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || m_ov) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain_timeout", {31'd0, (sb_q.size() != 0 || m_ov)}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_word",  {16'd0, out_word},  32'd0);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_bit_count", {28'd0, bit_count}, 32'd0);
    check_eq("rst_in_ready",  {31'd0, in_ready},  32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Continuous streaming, back-to-back words
    send_word(16'hA5C3, 0);
    check_eq("a5c3_valid", {31'd0, out_valid}, 32'd1);
    check_eq("a5c3_word",  {16'd0, out_word},  32'h0000A5C3);
    send_word(16'h1234, 0);
    wait_drain();

    // Backpressure on the completing bit
    out_ready = 1'b0;
    send_word(16'h00FF, 0);
    for (int i = 0; i < 15; i++) send_bit(1'b0 ^ (i >= 8), 0);
    in_valid = 1'b1; in_bit = 1'b1;
    #2;
    check_eq("bp_in_ready",  {31'd0, in_ready},  32'd0);
    check_eq("bp_bit_count", {28'd0, bit_count}, 32'd15);
    check_eq("bp_out_word",  {16'd0, out_word},  32'h000000FF);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("bp_new_word",  {16'd0, out_word},  32'h0000FF00);
    check_eq("bp_valid",     {31'd0, out_valid}, 32'd1);
    wait_drain();

    // Flush of a partial word
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    flush = 1'b1;
    #1;
    check_eq("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_bit_count", {28'd0, bit_count}, 32'd0);
    check_eq("flush_out_valid", {31'd0, out_valid}, 32'd0);
    send_word(16'h0001, 0);
    check_eq("flush_word", {16'd0, out_word}, 32'h00000001);
    wait_drain();

    // Asynchronous reset mid-word with a pending word
    out_ready = 1'b0;
    send_word(16'hBEEF, 0);
    for (int i = 0; i < 9; i++) send_bit(1'b1, 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_out_word",  {16'd0, out_word},  32'd0);
    check_eq("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("arst_bit_count", {28'd0, bit_count}, 32'd0);
    check_eq("arst_in_ready",  {31'd0, in_ready},  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    send_word(16'h5A5A, 0);
    check_eq("arst_word", {16'd0, out_word}, 32'h00005A5A);
    wait_drain();

    // MSB-first symmetric pattern with gaps
    out_ready = 1'b0;
    send_word(16'h8001, 2);
    check_eq("msb_8001", {16'd0, out_word_m}, 32'h00008001);
    out_ready = 1'b1;
    wait_drain();

    // Random words, random gaps and random consumer stalls
    rand_rdy = 1'b1;
    for (int k = 0; k < 100; k++) send_word(16'($urandom()), 2);
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
